// File: rtl/cke_scheduler_if.sv
// -----------------------------------------------------------------------------
// cke_scheduler_if
// Command port of the clock-enable scheduler: a valid/ready channel carrying
// one configuration command per transfer.
//
// Signals:
//   cfg_valid  master->slave  command valid
//   cfg_ready  slave->master  scheduler can accept a command
//   cfg_ch     master->slave  target channel, max(1,$clog2(N_CH)) bits
//   cfg_op     master->slave  00 SET_PERIOD, 01 SET_PHASE, 10 ENABLE, 11 DISABLE
//   cfg_data   master->slave  operand for SET_PERIOD / SET_PHASE, CNT_W bits
//
// Modports: master (command source), slave (scheduler).
// -----------------------------------------------------------------------------
interface cke_scheduler_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 26
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [1:0]       cfg_op;
   logic [CNT_W-1:0] cfg_data;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_op,
      output cfg_data,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_op,
      input  cfg_data,
      output cfg_ready
   );
endinterface

// File: rtl/cke_scheduler.sv
// -----------------------------------------------------------------------------
// cke_scheduler
// Programmable multi-channel clock-enable scheduler. Every channel owns a
// period counter, a phase offset and an IDLE/RUN state, all configured through
// one valid/ready command port. Each running channel emits a one-cycle tick
// whenever its counter is at zero; a global sync reloads all running channels
// to their phase at the same edge.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous reset, active-low
//   cfg     if   command port (cke_scheduler_if.slave)
//   sync    in   level-sampled realign of all running channels
//   tick    out  [N_CH] one-cycle enable strobe per channel
//   active  out  [N_CH] channel is in RUN
//   half    out  [N_CH] ~50% duty square wave aligned to tick
//                (present only when CKE_SCHED_HALF_EN is defined)
//   err     out  one-cycle pulse when a command is rejected
//
// Optional feature macro: CKE_SCHED_HALF_EN (adds the half output).
// -----------------------------------------------------------------------------
module cke_scheduler #(
   parameter int N_CH       = 4,
   parameter int CNT_W      = 26,
   parameter int DEF_PERIOD = 50000000
) (
   input  logic            clk,
   input  logic            rst,
   cke_scheduler_if.slave  cfg,
   input  logic            sync,
   output logic [N_CH-1:0] tick,
   output logic [N_CH-1:0] active,
`ifdef CKE_SCHED_HALF_EN
   output logic [N_CH-1:0] half,
`endif
   output logic            err
);
   localparam int               CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   localparam logic [1:0] OP_SET_PERIOD = 2'b00;
   localparam logic [1:0] OP_SET_PHASE  = 2'b01;
   localparam logic [1:0] OP_ENABLE     = 2'b10;
   localparam logic [1:0] OP_DISABLE    = 2'b11;

   typedef enum logic {ST_IDLE, ST_RUN} ch_state_t;

   logic                        cfg_ready_r;
   logic                        accept;
   logic                        reject;
   logic                        cmd_ok;
   logic [CNT_W-1:0]            sel_period;
   logic [N_CH-1:0][CNT_W-1:0]  period_all;

   assign cfg.cfg_ready = cfg_ready_r;
   assign accept        = cfg.cfg_valid && cfg_ready_r;
   assign cmd_ok        = accept && !reject;

   // Active period of the addressed channel, needed to validate SET_PHASE.
   always_comb begin
      sel_period = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (cfg.cfg_ch == CH_W'(i)) sel_period = period_all[i];
      end
   end

   always_comb begin
      reject = 1'b0;
      if (accept) begin
         case (cfg.cfg_op)
            OP_SET_PERIOD: reject = (cfg.cfg_data == '0);
            OP_SET_PHASE:  reject = (cfg.cfg_data >= sel_period);
            default:       reject = 1'b0;
         endcase
      end
   end

   // Handshake: ready drops for exactly one cycle after each accept, which
   // also makes it rise on the first edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_ready_r <= 1'b0;
         err         <= 1'b0;
      end else begin
         cfg_ready_r <= !accept;
         err         <= reject;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      ch_state_t        state;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] pend_period;
      logic [CNT_W-1:0] phase;
      logic [CNT_W-1:0] reload;
      logic             hit;
      logic             wrap;

      assign hit    = cmd_ok && (cfg.cfg_ch == CH_W'(g));
      // A stale phase that no longer fits the period restarts at zero.
      assign reload = (phase >= period) ? '0 : phase;
      assign wrap   = (cnt == period - ONE);

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            period      <= DEF_P;
            pend_period <= DEF_P;
            phase       <= '0;
         end else begin
            if (state == ST_RUN) begin
               // A sync reload is not a wrap: pend_period stays pending.
               if (sync) begin
                  cnt <= reload;
               end else if (wrap) begin
                  cnt    <= '0;
                  period <= pend_period;
               end else begin
                  cnt <= cnt + ONE;
               end
            end else begin
               cnt <= '0;
            end

            // Commands are evaluated last so DISABLE beats a same-edge sync.
            if (hit) begin
               case (cfg.cfg_op)
                  OP_SET_PERIOD: begin
                     pend_period <= cfg.cfg_data;
                     // A value arriving on the wrap edge itself is taken
                     // directly, otherwise the old pending value would win.
                     if (state == ST_IDLE || (wrap && !sync))
                        period <= cfg.cfg_data;
                  end
                  OP_SET_PHASE: phase <= cfg.cfg_data;
                  OP_ENABLE: begin
                     state <= ST_RUN;
                     cnt   <= reload;
                  end
                  OP_DISABLE: begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                  end
                  default: ;
               endcase
            end
         end
      end

      assign tick[g]       = (state == ST_RUN) && (cnt == '0);
      assign active[g]     = (state == ST_RUN);
      assign period_all[g] = period;

`ifdef CKE_SCHED_HALF_EN
      logic [CNT_W:0] half_lim;
      // One extra bit so period+1 cannot overflow.
      assign half_lim = ({1'b0, period} + (CNT_W+1)'(1)) >> 1;
      assign half[g]  = (state == ST_RUN) && ({1'b0, cnt} < half_lim);
`endif
   end
endmodule

// File: tb/tb_cke_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cke_scheduler
// Directed self-checking bench for cke_scheduler (DEF_PERIOD=10). Inputs are
// driven and outputs sampled on the falling clock edge; tick positions are
// recorded as offsets in cycles from the current falling edge.
// -----------------------------------------------------------------------------
module tb_cke_scheduler;
   localparam int N_CH       = 4;
   localparam int CNT_W      = 26;
   localparam int DEF_PERIOD = 10;

   localparam logic [1:0] OP_SP  = 2'b00;
   localparam logic [1:0] OP_PH  = 2'b01;
   localparam logic [1:0] OP_EN  = 2'b10;
   localparam logic [1:0] OP_DIS = 2'b11;

   logic            clk  = 1'b0;
   logic            rst  = 1'b0;
   logic            sync = 1'b0;
   logic [N_CH-1:0] tick;
   logic [N_CH-1:0] active;
   logic            err;
`ifdef CKE_SCHED_HALF_EN
   logic [N_CH-1:0] half;
`endif

   cke_scheduler_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

   cke_scheduler #(
      .N_CH      (N_CH),
      .CNT_W     (CNT_W),
      .DEF_PERIOD(DEF_PERIOD)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .cfg   (bus),
      .sync  (sync),
      .tick  (tick),
      .active(active),
`ifdef CKE_SCHED_HALF_EN
      .half  (half),
`endif
      .err   (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int first_t[N_CH];
   int cnt_t[N_CH];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge right after the
   // accept edge, where err and the new channel state are visible.
   task automatic send(input int ch, input logic [1:0] op, input logic [CNT_W-1:0] data);
      int waited = 0;
      while (bus.cfg_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (bus.cfg_ready !== 1'b1) begin
         check_eq("ready_timeout", 32'(bus.cfg_ready), 1);
         return;
      end
      bus.cfg_valid = 1'b1;
      bus.cfg_ch    = 2'(ch);
      bus.cfg_op    = op;
      bus.cfg_data  = data;
      @(negedge clk);
      bus.cfg_valid = 1'b0;
   endtask

   // Record first tick offset and tick count per channel over ncyc cycles.
   task automatic watch(input int ncyc);
      for (int c = 0; c < N_CH; c++) begin
         first_t[c] = -1;
         cnt_t[c]   = 0;
      end
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clk);
         for (int c = 0; c < N_CH; c++) begin
            if (tick[c]) begin
               if (first_t[c] < 0) first_t[c] = n;
               cnt_t[c]++;
            end
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N_CH-1:0] seen;
      bus.cfg_valid = 1'b0;
      bus.cfg_ch    = '0;
      bus.cfg_op    = '0;
      bus.cfg_data  = '0;

      // Reset and release
      repeat (3) @(negedge clk);
      check_eq("rst_ready", 32'(bus.cfg_ready), 0);
      check_eq("rst_tick", 32'(tick), 0);
      check_eq("rst_active", 32'(active), 0);
      check_eq("rst_err", 32'(err), 0);
      rst = 1'b1;
      #1;
      check_eq("ready_before_edge", 32'(bus.cfg_ready), 0);
      @(negedge clk);
      check_eq("ready_after_edge", 32'(bus.cfg_ready), 1);
      seen = '0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         seen = seen | tick | active;
      end
      check_eq("idle_50_cycles", 32'(seen), 0);

      // ch0 period 4, phase 0
      send(0, OP_SP, 4);
      check_eq("sp4_err", 32'(err), 0);
      send(0, OP_EN, 0);
      check_eq("en0_tick_latency", 32'(tick[0]), 1);
      check_eq("en0_active", 32'(active[0]), 1);
      watch(8);
      check_eq("p4_first", first_t[0], 4);
      check_eq("p4_count", cnt_t[0], 2);

      // ch1 period 8, phase 3
      send(1, OP_SP, 8);
      send(1, OP_PH, 3);
      check_eq("ph3_err", 32'(err), 0);
      send(1, OP_EN, 0);
      check_eq("en1_no_tick", 32'(tick[1]), 0);
      check_eq("en1_active", 32'(active[1]), 1);
      watch(12);
      check_eq("ph3_first", first_t[1], 5);
      check_eq("ph3_count", cnt_t[1], 1);

      // sync realigns both running channels
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      check_eq("sync_tick0", 32'(tick[0]), 1);
      check_eq("sync_tick1", 32'(tick[1]), 0);
      watch(6);
      check_eq("sync_ch0_first", first_t[0], 4);
      check_eq("sync_ch1_first", first_t[1], 5);

      // Period change mid-interval at cnt=1 takes effect at the wrap
      repeat (3) @(negedge clk);
      send(0, OP_SP, 6);
      watch(14);
      check_eq("pend_first", first_t[0], 2);
      check_eq("pend_count", cnt_t[0], 3);

      // Rejected commands
      send(0, OP_SP, 0);
      check_eq("sp0_err", 32'(err), 1);
      @(negedge clk);
      check_eq("sp0_err_pulse", 32'(err), 0);
      send(1, OP_PH, 9);
      check_eq("ph9_err", 32'(err), 1);
      @(negedge clk);
      check_eq("ph9_err_pulse", 32'(err), 0);
      watch(8);
      check_eq("rej_ch0_first", first_t[0], 2);
      check_eq("rej_ch0_count", cnt_t[0], 2);
      check_eq("rej_ch1_first", first_t[1], 1);

      // Back-to-back valid: second command ignored while ready is low
      bus.cfg_valid = 1'b1;
      bus.cfg_ch    = 2'd1;
      bus.cfg_op    = OP_PH;
      bus.cfg_data  = 2;
      @(negedge clk);
      check_eq("b2b_ready_low", 32'(bus.cfg_ready), 0);
      check_eq("b2b_first_err", 32'(err), 0);
      bus.cfg_op   = OP_SP;
      bus.cfg_data = 0;
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      check_eq("b2b_second_ignored", 32'(err), 0);

      // Sync and DISABLE ch0 at the same edge
      bus.cfg_valid = 1'b1;
      bus.cfg_ch    = 2'd0;
      bus.cfg_op    = OP_DIS;
      bus.cfg_data  = 0;
      sync          = 1'b1;
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      sync          = 1'b0;
      check_eq("dis_active0", 32'(active[0]), 0);
      check_eq("dis_tick0", 32'(tick[0]), 0);
      check_eq("dis_active1", 32'(active[1]), 1);
      watch(10);
      check_eq("dis_ch0_count", cnt_t[0], 0);
      check_eq("sync_new_phase_first", first_t[1], 6);
      check_eq("sync_new_phase_count", cnt_t[1], 1);

      // period 1 ticks every cycle
      send(2, OP_SP, 1);
      send(2, OP_EN, 0);
      check_eq("p1_tick", 32'(tick[2]), 1);
      watch(3);
      check_eq("p1_count", cnt_t[2], 3);

      // Asynchronous reset mid-run while err is high
      send(2, OP_SP, 0);
      check_eq("final_err", 32'(err), 1);
      check_eq("final_tick2", 32'(tick[2]), 1);
      #2;
      rst = 1'b0;
      #1;
      check_eq("async_tick", 32'(tick), 0);
      check_eq("async_active", 32'(active), 0);
      check_eq("async_err", 32'(err), 0);
      check_eq("async_ready", 32'(bus.cfg_ready), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cke_scheduler.md
Name: cke_scheduler

Overview:
- Programmable multi-channel clock-enable scheduler; replaces fixed-period enable generators wherever periods must change at run time.
- Each channel has its own period counter, phase offset and run state, configured through a single valid/ready command port.
- Emits one-cycle tick strobes that downstream blocks in the utils and peripheral layers use as clock enables.
- A global sync input realigns all running channels.

Parameters:
- N_CH, 4, number of channels; must be at least 1.
- CNT_W, 26, width of the period, phase and counter fields.
- DEF_PERIOD, 50000000, reset period of every channel; must satisfy 1 <= DEF_PERIOD < 2**CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low; state is cleared while rst==0.
- cfg_valid  in  1  command valid.
- cfg_ready  out  1  scheduler can accept a command.
- cfg_ch  in  max(1,$clog2(N_CH))  target channel.
- cfg_op  in  2  operation: 00 SET_PERIOD, 01 SET_PHASE, 10 ENABLE, 11 DISABLE.
- cfg_data  in  CNT_W  operand for SET_PERIOD and SET_PHASE; ignored otherwise.
- sync  in  1  restart all running channels at their phase.
- tick  out  N_CH  per-channel one-cycle enable strobe.
- active  out  N_CH  channel is in the RUN state.
- err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset values: cnt=0; period=DEF_PERIOD; pend_period=DEF_PERIOD; phase=0; all channels IDLE; tick=0; active=0; err=0; cfg_ready=0.
- After reset: cfg_ready rises on the first clk edge after rst deasserts.
- Handshake:
  - A command is accepted on a clk edge where cfg_valid && cfg_ready.
  - cfg_ready is 0 in the following cycle, then returns to 1. Maximum rate is one command per 2 cycles.
  - cfg_valid while cfg_ready==0 is ignored; the command is not queued.
- Per-channel state machine:
  - IDLE: cnt held at 0, tick=0. ENABLE moves to RUN and loads cnt=phase, or cnt=0 if phase>=period.
  - RUN: cnt increments each cycle. When cnt==period-1, cnt wraps to 0 and period<=pend_period. DISABLE moves to IDLE and clears cnt.
  - ENABLE on a running channel re-loads cnt exactly as above. DISABLE on an IDLE channel has no effect. Neither raises err.
- Outputs:
  - tick[i] = RUN && cnt==0, decoded from registers and never high in IDLE. active[i] = RUN.
  - Latency: ENABLE accepted at edge k with phase 0 gives tick high in the cycle after edge k. Subsequent ticks follow every period cycles.
- SET_PERIOD:
  - cfg_data==0 is rejected: err pulses for 1 cycle and state is unchanged.
  - Otherwise pend_period is written. In IDLE, period is also written immediately. In RUN, the new value takes effect at the next wrap, so the current interval completes with the old period.
  - period==1 gives tick every cycle.
- SET_PHASE:
  - cfg_data>=period (current active period) is rejected with err.
  - Otherwise phase is stored. It applies only on the next ENABLE or sync; cnt is untouched.
- sync:
  - Level-sampled each cycle.
  - Every RUN channel loads cnt=phase, or 0 if phase>=period, at the same edge.
  - IDLE channels are unaffected.
- Simultaneous sync and command at the same edge:
  - ENABLE: the channel starts at phase, which is identical to the sync result.
  - DISABLE: disable wins and the channel goes IDLE.
  - SET_PERIOD: the command applies as normal. A sync reload is not a wrap, so pend_period does not transfer.
- Counter width:
  - All comparisons are unsigned on CNT_W bits.
  - cnt never exceeds period-1. If period shrinks below cnt through an IDLE write, the IDLE clear guarantees cnt=0.
- Reset mid-operation: asynchronous return to reset values. tick drops in the same cycle rst falls.

Optional Feature:
- Macro: CKE_SCHED_HALF_EN.
- Defined:
  - Adds output port half, width N_CH.
  - half[i] = RUN && cnt < ((period+1)>>1), giving an approximately 50% duty square wave aligned to tick.
  - half=0 in IDLE and in reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, DEF_PERIOD=10: cfg_ready=1 one edge after rst rises; tick=0, active=0 for 50 cycles.
- SET_PERIOD ch0=4 then ENABLE ch0 (phase 0): tick[0] high in the cycle after the accept edge, then every 4 cycles; active[0]=1.
- ch1 period 8, SET_PHASE 3, ENABLE: first tick[1] 5 cycles after the load cycle; assert sync later: all RUN channels reload, ch0 ticks 1 cycle after sync and ch1 5 cycles after.
- ch0 running at 4, SET_PERIOD 6 at cnt=1: next tick is still 3 cycles later; intervals thereafter are 6.
- SET_PERIOD 0 and SET_PHASE 9 with period 8: err pulses one cycle each; tick timing unchanged; back-to-back cfg_valid: the second command is ignored while cfg_ready=0.
- Sync and DISABLE ch0 at the same edge: active[0]=0 and no further tick[0]; rst low mid-run: tick, active and err clear asynchronously.
